// File: rtl/payload_fcs_checker_pkg.sv
// payload_fcs_checker_pkg: CRC-32 constants, FSM encoding and default payload limits
package payload_fcs_checker_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam int DEF_MIN_PAYLOAD = 46;
  localparam int DEF_MAX_PAYLOAD = 1500;
  typedef enum logic [1:0] {IDLE, RECV, DONE, ERR} state_t;
endpackage

// File: rtl/payload_fcs_checker_crc32_byte_update.sv
// crc32_byte_update: one-byte reflected CRC-32 step, eight unrolled shifts
module crc32_byte_update
  import payload_fcs_checker_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  logic [31:0] c;
  always_comb begin
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY_REFL : c >> 1;
    crc_next = c;
  end
endmodule

// File: rtl/payload_fcs_checker.sv
// payload_fcs_checker: counts payload+FCS bytes, checks size limits and CRC-32 residue
module payload_fcs_checker
  import payload_fcs_checker_pkg::*;
#(
  parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
  parameter int FCS_BYTES   = 4,
  parameter int CNT_W       = 11
)(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       last,
  output logic       done,
  output logic       packet_size_valid,
  output logic       crc_valid,
  output logic       overflow
);
  localparam int LIMIT = MAX_PAYLOAD + FCS_BYTES;
  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] cnt_inc;
  logic [31:0] crc, crc_upd;
  logic size_ok, fcs_ok, accept, at_limit, size_now, fcs_now;
  crc32_byte_update u_crc (.crc(crc), .data(data_in), .crc_next(crc_upd));
  assign accept   = enable && data_valid && (state == IDLE || state == RECV);
  assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
  assign at_limit = cnt == CNT_W'(LIMIT);
  // comparing the total against MIN+FCS avoids subtracting, so short frames cannot wrap
  assign size_now = cnt_inc >= (CNT_W+1)'(MIN_PAYLOAD + FCS_BYTES) && cnt_inc <= (CNT_W+1)'(LIMIT);
  assign fcs_now  = FCS_BYTES == 0 || crc_upd == CRC32_RESIDUE;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = !enable ? IDLE :
                 accept && last ? DONE :
                 accept && at_limit ? ERR :
                 state == IDLE ? RECV : state;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || !enable) begin
      cnt     <= '0;
      crc     <= CRC32_INIT;
      size_ok <= 1'b0;
      fcs_ok  <= 1'b0;
    end else if (accept) begin
      cnt     <= at_limit ? cnt : cnt_inc[CNT_W-1:0];
      crc     <= crc_upd;
      size_ok <= last && size_now;
      fcs_ok  <= last && fcs_now;
    end
  end
  always_comb begin
    done              = state == DONE || state == ERR;
    overflow          = state == ERR;
    packet_size_valid = state == DONE && size_ok;
    crc_valid         = state == DONE && fcs_ok;
  end
endmodule

// File: tb/tb_payload_fcs_checker.sv
// tb_payload_fcs_checker: scoreboard bench, one DUT with MIN_PAYLOAD=9 and one with defaults
module tb_payload_fcs_checker;
  logic clock = 0, reset_n = 0, enable = 0, data_valid = 0, last = 0;
  logic [7:0] data_in = 0;
  logic done_a, psv_a, crc_a, ovf_a, done_b, psv_b, crc_b, ovf_b;
  int total = 0, bad = 0;
  typedef struct { bit done, psv_a, psv_b, crc, ovf; } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic [7:0] fr[$];

  always #5 clock = ~clock;

  payload_fcs_checker #(.MIN_PAYLOAD(9)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .last(last), .done(done_a),
    .packet_size_valid(psv_a), .crc_valid(crc_a), .overflow(ovf_a));
  payload_fcs_checker dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .last(last), .done(done_b),
    .packet_size_valid(psv_b), .crc_valid(crc_b), .overflow(ovf_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_reg(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return c;
  endfunction

  task automatic build(input int n);
    logic [31:0] f;
    fr = {};
    for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    f = ~crc_reg(fr);
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
  endtask

  task automatic push_exp(input bit d, input bit pa, input bit pb, input bit c, input bit o);
    exp_t e;
    e.done = d; e.psv_a = pa; e.psv_b = pb; e.crc = c; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int n, input bit crc_ok);
    push_exp(1, n >= 9 && n <= 1500, n >= 46 && n <= 1500, crc_ok, 0);
  endtask

  task automatic send(input bit gaps, input bit with_last, input bit drop_on_last);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(negedge clock); data_valid = 0; last = 0;
      end
      @(negedge clock);
      data_in = fr[i]; data_valid = 1;
      last = with_last && i == fr.size() - 1;
      enable = !(drop_on_last && i == fr.size() - 1);
    end
    @(negedge clock); data_valid = 0; last = 0;
  endtask

  task automatic cmp_outputs(input string tag);
    chk({tag, "_done_a"}, done_a, cur.done);
    chk({tag, "_done_b"}, done_b, cur.done);
    chk({tag, "_psv_a"}, psv_a, cur.psv_a);
    chk({tag, "_psv_b"}, psv_b, cur.psv_b);
    chk({tag, "_crc_a"}, crc_a, cur.crc);
    chk({tag, "_crc_b"}, crc_b, cur.crc);
    chk({tag, "_ovf_a"}, ovf_a, cur.ovf);
    chk({tag, "_ovf_b"}, ovf_b, cur.ovf);
  endtask

  task automatic expect_result(input string tag);
    int k = 0;
    while (!done_a && k < 8) begin @(negedge clock); k++; end
    chk({tag, "_latency"}, k, 0);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else begin
      cur = sb.pop_front();
      cmp_outputs(tag);
    end
  endtask

  task automatic hold_and_clear(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); data_in = 8'($urandom); data_valid = 1; last = i == 2;
    end
    @(negedge clock); data_valid = 0; last = 0;
    cmp_outputs({tag, "_hold"});
    enable = 0;
    @(negedge clock);
    chk({tag, "_clr_done"}, done_a, 0);
    chk({tag, "_clr_ovf"}, ovf_b, 0);
  endtask

  task automatic run_good(input int n, input bit gaps, input string tag);
    build(n);
    push_frame(n, 1);
    send(gaps, 1, 0);
    expect_result(tag);
    hold_and_clear(tag);
  endtask

  initial begin
    #3;
    chk("rst_done", done_a, 0);
    chk("rst_psv", psv_b, 0);
    chk("rst_crc", crc_a, 0);
    chk("rst_ovf", ovf_b, 0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    fr = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    push_exp(1, 1, 0, 1, 0);
    send(0, 1, 0);
    expect_result("vec");
    hold_and_clear("vec");
    fr[9] = 8'h27;
    push_exp(1, 1, 0, 0, 0);
    send(0, 1, 0);
    expect_result("vec_bad");
    hold_and_clear("vec_bad");
    run_good(45, 0, "p45");
    run_good(46, 0, "p46");
    run_good(1500, 0, "p1500");
    fr = {8'h00, 8'h00};
    push_exp(1, 0, 0, crc_reg(fr) == 32'hDEBB20E3, 0);
    send(0, 1, 0);
    expect_result("short");
    hold_and_clear("short");
    fr = {};
    for (int i = 0; i < 1505; i++) fr.push_back(8'($urandom));
    push_exp(1, 0, 0, 0, 1);
    send(0, 0, 0);
    expect_result("ovf");
    hold_and_clear("ovf");
    build(16);
    send(0, 0, 0);
    chk("abort_nodone", done_a, 0);
    enable = 0;
    @(negedge clock);
    run_good(46, 0, "after_abort");
    build(46);
    send(0, 1, 1);
    chk("drop_last_done_a", done_a, 0);
    chk("drop_last_done_b", done_b, 0);
    @(negedge clock);
    run_good(60, 1, "gaps");
    build(50);
    push_frame(50, 1);
    send(1, 1, 0);
    expect_result("pre_rst");
    #2 reset_n = 0;
    #1;
    chk("arst_done", done_a, 0);
    chk("arst_psv", psv_a, 0);
    chk("arst_crc", crc_b, 0);
    enable = 0;
    @(negedge clock);
    reset_n = 1;
    run_good(46, 1, "post_rst");
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/payload_fcs_checker.md
# payload_fcs_checker

Parametrised successor to the fixed 50-byte payload/CRC counter in the frame-parsing pipeline. The block accepts the payload and FCS bytes of one frame from the header parser and counts them against configurable minimum and maximum payload lengths. It computes CRC-32 (Ethernet, reflected) on the fly and reports size validity, FCS validity and overflow once the frame's final byte is seen. It sits downstream of the header/length parsing stages and feeds the frame-accept logic.

## Interface
- MIN_PAYLOAD, 46, minimum legal payload bytes (FCS excluded)
- MAX_PAYLOAD, 1500, maximum legal payload bytes (FCS excluded)
- FCS_BYTES, 4, trailer bytes; fixed at 4 for CRC-32, FCS check disabled if 0
- CNT_W, 11, byte-counter width; must satisfy 2^CNT_W > MAX_PAYLOAD + FCS_BYTES
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  high while the payload/FCS section is being parsed; low clears the block synchronously
- data_in  input  8  payload/FCS byte
- data_valid  input  1  data_in carries a byte this cycle
- last  input  1  qualifies data_valid; marks the final FCS byte
- done  output  1  result outputs valid; held until enable falls
- packet_size_valid  output  1  MIN_PAYLOAD ≤ payload bytes ≤ MAX_PAYLOAD
- crc_valid  output  1  FCS matches computed CRC (forced 1 if FCS_BYTES = 0)
- overflow  output  1  more than MAX_PAYLOAD + FCS_BYTES bytes arrived without last

## Operation
- States: IDLE, RECV, DONE, ERR.
- IDLE: counter = 0, CRC register = 32'hFFFFFFFF. enable = 1 → RECV (same-cycle byte is accepted; see below).
- RECV: each cycle with data_valid = 1 accepts one byte. Counter increments by 1. CRC updates LSB-first, polynomial 32'hEDB88320, over all bytes including the FCS.
- Byte accepted with last = 1 → DONE.
  - packet_size_valid = (count_incl_this_byte − FCS_BYTES) within [MIN_PAYLOAD, MAX_PAYLOAD].
  - crc_valid = (updated CRC register == 32'hDEBB20E3), the residue. No final XOR.
  - done = 1.
- Counter reaching MAX_PAYLOAD + FCS_BYTES with a further non-last byte accepted → ERR with overflow = 1, done = 1, and packet_size_valid = crc_valid = 0.
- Frame shorter than FCS_BYTES at last → packet_size_valid = 0, and the subtraction must not wrap.
- DONE/ERR: outputs held and further bytes ignored until enable = 0.
- enable = 0 in any state → next cycle IDLE with all outputs 0. This covers mid-frame abort.
- data_valid with enable = 0 is ignored.
- Counter saturates and never wraps.

## Timing
- reset_n low: state IDLE, counter 0, CRC all-ones, done = packet_size_valid = crc_valid = overflow = 0, taking effect immediately (asynchronous).
- Latency: flags and done register on the clock edge that accepts the last byte, so they are visible the cycle after that byte.
- Throughput: one byte per cycle with no back-pressure; data_valid may gap arbitrarily.
- enable rising with data_valid = 1 in the same cycle: that byte is counted as byte 0.
- enable falling and last in the same cycle: enable wins, the byte is dropped and the block goes to IDLE.
- reset_n deassertion is synchronised externally; the block behaves correctly from the first edge after release.

## Structure
- Shared package holds:
  - CRC constants: CRC32_POLY_REFL = 32'hEDB88320, CRC32_INIT = 32'hFFFFFFFF, CRC32_RESIDUE = 32'hDEBB20E3.
  - The state-encoding typedef.
  - The default MIN/MAX payload constants, shared with the header parser.
- One sub-module, crc32_byte_update. It is combinational: 32-bit CRC in plus 8-bit data in → 32-bit CRC out, eight unrolled reflected shift steps. It is reused by the future transmit-side FCS generator.

## Test plan
- MIN_PAYLOAD = 9: payload "123456789" (31..39), then FCS 26 39 F4 CB with last on CB → done, packet_size_valid = 1, crc_valid = 1, overflow = 0, one cycle after CB.
- Same frame with the FCS first byte corrupted to 27 → crc_valid = 0, packet_size_valid = 1.
- Defaults, 45-byte payload with correct FCS → packet_size_valid = 0, crc_valid = 1. Repeat with 46 and 1500 bytes → packet_size_valid = 1.
- Defaults, 1505 bytes with no last → overflow = 1, done = 1, flags 0; later bytes ignored.
- enable dropped after 20 bytes, then a fresh valid 46-byte frame → first frame produces no done; second reports packet_size_valid = crc_valid = 1.
- reset_n pulsed low mid-frame between clock edges → all outputs 0 immediately. Random data_valid gaps on a good frame → results identical to a gap-free frame.
